// File: rtl/ecc_host_loader.sv
// ecc_host_loader: packs 32 host words into four 256-bit RAM chunks, writes the start
// command and polls the status word. Define LOADER_TIMEOUT_EN to bound status polling.
module ecc_host_loader #(
  parameter int              DATA          = 255,
  parameter int              ADDR          = 5,
  parameter logic [ADDR:0]   START_ADDR    = 6'h14,
  parameter logic [ADDR:0]   CMD_ADDR      = 6'h00,
  parameter logic [ADDR:0]   STATUS_ADDR   = 6'h01,
  parameter logic [15:0]     TIMEOUT_POLLS = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              a_w,
  output logic [ADDR:0]     a_adbus,
  output logic [DATA:0]     a_data_in,
  input  logic [DATA:0]     a_data_out,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PACK      = 3'd1,
    S_WRITE     = 3'd2,
    S_CMD       = 3'd3,
    S_POLL_ADDR = 3'd4,
    S_POLL_WAIT = 3'd5,
    S_DONE      = 3'd6,
    S_ERR       = 3'd7
  } state_t;

  localparam int PB = $clog2(DATA + 1);

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_chunk;
  logic [2:0]      r_beat;
  logic [DATA:0]   r_pack;
  logic            w_beat;
  logic            w_begin;
  logic            w_timeout;
  logic [PB-1:0]   w_lo;
  logic [ADDR:0]   w_chunk_ext;

  // Handshake: a beat transfers on a rising edge where s_valid && s_ready; s_ready is high only in PACK.
  assign w_beat      = (r_state == S_PACK) && s_valid;
  assign w_begin     = start && ((r_state == S_IDLE) || (r_state == S_ERR));
  assign w_lo        = PB'(DATA - 31 - 32 * int'(r_beat));
  assign w_chunk_ext = {{(ADDR-1){1'b0}}, r_chunk};

`ifdef LOADER_TIMEOUT_EN
  logic [15:0] r_polls;
  logic        w_unused;
  assign w_unused  = ^a_data_out[DATA:1];
  assign w_timeout = ((r_polls + 16'd1) == TIMEOUT_POLLS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       r_polls <= '0;
    else if (r_state == S_CMD)                        r_polls <= '0;
    else if (r_state == S_POLL_WAIT && !a_data_out[0]) r_polls <= r_polls + 16'd1;
  end
`else
  logic w_unused;
  assign w_unused  = ^{a_data_out[DATA:1], TIMEOUT_POLLS};
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (start) w_next = S_PACK;
      S_PACK: begin
        // s_last must coincide exactly with the final beat of the final chunk
        if (s_valid) begin
          if (r_beat == 3'd7) w_next = (s_last == (r_chunk == 2'd3)) ? S_WRITE : S_ERR;
          else if (s_last)    w_next = S_ERR;
        end
      end
      S_WRITE:     w_next = (r_chunk == 2'd3) ? S_CMD : S_PACK;
      S_CMD:       w_next = S_POLL_ADDR;
      S_POLL_ADDR: w_next = S_POLL_WAIT;
      S_POLL_WAIT: begin
        if (a_data_out[0]) w_next = S_DONE;
        else if (w_timeout) w_next = S_ERR;
        else               w_next = S_POLL_ADDR;
      end
      S_DONE:      w_next = S_IDLE;
      S_ERR:       if (start) w_next = S_PACK;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chunk <= '0;
      r_beat  <= '0;
      r_pack  <= '0;
    end else if (w_begin) begin
      r_chunk <= '0;
      r_beat  <= '0;
    end else if (w_beat) begin
      r_pack[w_lo +: 32] <= s_data;
      r_beat             <= r_beat + 3'd1;
    end else if (r_state == S_WRITE) begin
      r_chunk <= r_chunk + 2'd1;
    end
  end

  always_comb begin
    s_ready   = 1'b0;
    a_w       = 1'b0;
    a_adbus   = '0;
    a_data_in = '0;
    case (r_state)
      S_PACK:      s_ready = 1'b1;
      S_WRITE: begin
        a_w       = 1'b1;
        a_adbus   = START_ADDR + w_chunk_ext;
        a_data_in = r_pack;
      end
      S_CMD: begin
        a_w          = 1'b1;
        a_adbus      = CMD_ADDR;
        a_data_in[1] = 1'b1;
      end
      S_POLL_ADDR: a_adbus = STATUS_ADDR;
      default: ;
    endcase
  end

  assign busy      = (r_state != S_IDLE) && (r_state != S_ERR);
  assign done      = (r_state == S_DONE);
  assign error     = (r_state == S_ERR);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ecc_host_loader.sv
// Bench for ecc_host_loader: RAM/status responder, operand driver, queue scoreboard.
// Define LOADER_TIMEOUT_EN to also exercise the bounded-polling case.
module tb_ecc_host_loader;

  localparam logic [5:0] MAIN_BASE = 6'h14;
  localparam logic [5:0] WRAP_BASE = 6'h3E;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [31:0]  s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready, a_w, busy, done, error;
  logic [5:0]   a_adbus;
  logic [255:0] a_data_in;
  logic [255:0] a_data_out = '0;
  logic [2:0]   dbg_state_unused;
  logic         wr_s_ready, wr_a_w, wr_busy, wr_done, wr_error;
  logic [5:0]   wr_a_adbus;
  logic [255:0] wr_a_data_in;
  logic [255:0] wr_data_out = '0;
  logic [2:0]   wr_dbg_unused;

  int total = 0;
  int bad   = 0;
  int poll_cnt = 0;
  int ok_poll;
  logic poll_clr;
  logic chk_wrap;
  logic [31:0]  words [32];
  logic [261:0] exp_q[$], act_q[$], wrap_exp[$], wrap_act[$];

  // ---------------- clock / DUTs ----------------
  always #5 clk = ~clk;

  ecc_host_loader #(
`ifdef LOADER_TIMEOUT_EN
    .TIMEOUT_POLLS(16'd4),
`endif
    .START_ADDR(MAIN_BASE)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .a_w(a_w), .a_adbus(a_adbus),
    .a_data_in(a_data_in), .a_data_out(a_data_out), .busy(busy), .done(done),
    .error(error), .dbg_state(dbg_state_unused)
  );

  ecc_host_loader #(.START_ADDR(WRAP_BASE)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(wr_s_ready), .a_w(wr_a_w), .a_adbus(wr_a_adbus),
    .a_data_in(wr_a_data_in), .a_data_out(wr_data_out), .busy(wr_busy), .done(wr_done),
    .error(wr_error), .dbg_state(wr_dbg_unused)
  );

  // RAM side: log writes, answer status reads one cycle after the address
  wire w_poll = busy && !a_w && (a_adbus == 6'h01);
  always @(posedge clk) begin
    if (a_w) act_q.push_back({a_adbus, a_data_in});
    if (poll_clr)    poll_cnt <= 0;
    else if (w_poll) poll_cnt <= poll_cnt + 1;
    a_data_out <= {255'b0, w_poll && (ok_poll != 0) && (poll_cnt + 1 >= ok_poll)};
    if (wr_a_w && chk_wrap) wrap_act.push_back({wr_a_adbus, wr_a_data_in});
    wr_data_out <= {255'b0, wr_busy && !wr_a_w && (wr_a_adbus == 6'h01)};
  end

  // A host beat must never be offered while a chunk is being written
  always @(negedge clk) begin
    if (rst_n && a_w) begin
      total++;
      assert (s_ready === 1'b0) else begin
        bad++;
        $error("FAIL ready_in_write observed=%0b expected=0", s_ready);
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [261:0] obs, input logic [261:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: chunk c holds words 8c..8c+7 with the first word in the top bits
  task automatic build_exp(input int n, input int last_pos, input logic [5:0] base, output bit err);
    logic [255:0] w;
    exp_q.delete();
    err = 0;
    w = '0;
    for (int c = 0; c < 4; c++) begin
      if (8 * (c + 1) > n) begin
        for (int i = 8 * c; i < n; i++) if (i + 1 == last_pos) err = 1;
        return;
      end
      for (int k = 0; k < 8; k++) begin
        w[255 - 32 * k -: 32] = words[8 * c + k];
        if ((8 * c + k + 1 == last_pos) != (8 * c + k + 1 == 32)) err = 1;
      end
      if (err) return;
      exp_q.push_back({base + 6'(c), w});
    end
    exp_q.push_back({6'h00, 256'h2});
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_wr_count"}, 262'(act_q.size()), 262'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check({tag, "_wr"}, act_q[i], exp_q[i]);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_a_w"}, a_w, 0);
    check({tag, "_a_adbus"}, a_adbus, 0);
    check({tag, "_a_data_in"}, a_data_in, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [31:0] d, input logic l, input bit gap, output bit ok);
    int guard = 0;
    bit hs = 0;
    if (gap) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!hs && guard < 40) begin
      hs = s_ready;
      @(negedge clk);
      guard++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    ok = hs;
  endtask

  task automatic begin_load(input int n, input int last_pos, input int gap_mode,
                            input int ok_p, input int start_at, output bit exp_err);
    bit ok;
    bit g;
    build_exp(n, last_pos, MAIN_BASE, exp_err);
    ok_poll = ok_p;
    @(negedge clk);
    act_q.delete();
    poll_clr = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    poll_clr = 1'b0;
    start    = 1'b0;
    check("busy_after_start", busy, 1);
    check("error_cleared", error, 0);
    for (int i = 0; i < n; i++) begin
      g = (gap_mode == 1) ? 1'b1 : (gap_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (i == start_at) start = 1'b1;
      send_word(words[i], (i + 1 == last_pos), g, ok);
      start = 1'b0;
      check("beat_accept", ok, 1);
      if (!ok) break;
    end
  endtask

  task automatic finish_load(input string tag, input bit exp_err, input bit exp_to, input int ok_p);
    int dc = 0;
    int cyc = 0;
    while (busy && cyc < 400) begin
      @(negedge clk);
      if (done) dc++;
      cyc++;
    end
    check({tag, "_idle"}, busy, 0);
    check({tag, "_done_pulses"}, 262'(dc), (exp_err || exp_to) ? 262'd0 : 262'd1);
    check({tag, "_error"}, error, exp_err || exp_to);
    check({tag, "_polls"}, 262'(poll_cnt), exp_to ? 262'd4 : exp_err ? 262'd0 : 262'(ok_p));
    compare_writes(tag);
  endtask

  task automatic run_load(input string tag, input int n, input int last_pos, input int gap_mode,
                          input int ok_p, input int start_at, input bit exp_to);
    bit e;
    begin_load(n, last_pos, gap_mode, ok_p, start_at, e);
    finish_load(tag, e, exp_to, ok_p);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit e;
    rst_n = 1'b0; start = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
    ok_poll = 1; poll_clr = 1'b0; chk_wrap = 1'b0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // nominal stream 1..32, status ready on the third poll
    for (int i = 0; i < 32; i++) words[i] = 32'(i + 1);
    run_load("nominal", 32, 32, 0, 3, -1, 1'b0);
    check("nominal_chunk0_literal", act_q[0],
          {6'h14, 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008});

    // host toggling s_valid every cycle
    run_load("backpressure", 32, 32, 1, 3, -1, 1'b0);

    // s_last arriving early on word 10
    run_load("early_last", 10, 10, 0, 3, -1, 1'b0);

    // s_last missing on word 32
    run_load("missing_last", 32, 0, 0, 3, -1, 1'b0);

    // reset mid-load after word 20, then a full reload
    for (int i = 0; i < 32; i++) words[i] = $urandom;
    begin_load(20, 32, 0, 3, -1, e);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    compare_writes("midreset");
    run_load("after_reset", 32, 32, 0, 2, -1, 1'b0);

    // random data with random host gaps
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 32; i++) words[i] = $urandom;
      run_load("random", 32, 32, 2, $urandom_range(1, 4), -1, 1'b0);
    end

    // stray start while packing; second instance wraps its chunk addresses
    for (int i = 0; i < 32; i++) words[i] = $urandom;
    build_exp(32, 32, WRAP_BASE, e);
    wrap_exp = exp_q;
    wrap_act.delete();
    chk_wrap = 1'b1;
    run_load("start_in_pack", 32, 32, 0, 1, 12, 1'b0);
    chk_wrap = 1'b0;
    check("wrap_wr_count", 262'(wrap_act.size()), 262'(wrap_exp.size()));
    for (int i = 0; i < wrap_exp.size() && i < wrap_act.size(); i++)
      check("wrap_wr", wrap_act[i], wrap_exp[i]);

`ifdef LOADER_TIMEOUT_EN
    // status never ready: four polls then fault
    for (int i = 0; i < 32; i++) words[i] = $urandom;
    run_load("timeout", 32, 32, 0, 0, -1, 1'b1);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
